mat_mac_seq: RTL and testbench

- Parametrised, sequential N x N matrix engine: element-wise ADD and SUB, matrix MUL, and accumulating matrix MAC (R = R + A*B).
- Operands enter flattened over a valid/ready handshake. MUL and MAC run one product per cycle through a single multiplier.
- The result is held in an internal accumulator matrix and returned flattened over a second valid/ready handshake.
- Sits between the operand buffer and the writeback path of the matrix co-processor.

---
 rtl/mat_mac_seq_if.sv | 34 +++
 rtl/mat_mac_seq.sv | 179 +++++++++++++++++
 tb/tb_mat_mac_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_mac_seq_if.sv
//------------------------------------------------------------------------------
// Module  : mat_mac_seq_if
// Brief   : Operand/result valid-ready bundle for the mat_mac_seq matrix engine.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mat_mac_seq_if #(
    parameter int N     = 3,
    parameter int EW    = 8,
    parameter int ACC_W = 20
);
    logic                   valid_i;
    logic                   ready_o;
    logic [1:0]             opcode_i;
    logic [N*N*EW-1:0]      mat_a_i;
    logic [N*N*EW-1:0]      mat_b_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [N*N*ACC_W-1:0]   result_o;
    logic                   sat_o;

    modport slave (
        input  valid_i, opcode_i, mat_a_i, mat_b_i, ready_i,
        output ready_o, valid_o, result_o, sat_o
    );

    modport master (
        output valid_i, opcode_i, mat_a_i, mat_b_i, ready_i,
        input  ready_o, valid_o, result_o, sat_o
    );
endinterface

`default_nettype wire

// File: rtl/mat_mac_seq.sv
//------------------------------------------------------------------------------
// Module  : mat_mac_seq
// Brief   : Sequential N x N matrix ADD/SUB/MUL/MAC engine, one product per
//           cycle. Define MAT_MAC_SAT_EN for saturating arithmetic and sat_o.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mat_mac_seq #(
    parameter int N     = 3,
    parameter int EW    = 8,
    parameter int ACC_W = 20
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        clr_i,
    mat_mac_seq_if.slave     bus
);

`ifdef MAT_MAC_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    localparam int c_ne = N * N;
    localparam int c_cw = $clog2(N);
    localparam int c_iw = $clog2(N * N);
    localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_mul = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [EW-1:0]      r_a   [c_ne];
    logic [EW-1:0]      r_b   [c_ne];
    logic [ACC_W-1:0]   r_acc [c_ne];
    logic [1:0]         r_op;
    logic [ACC_W-1:0]   r_sum;
    logic [c_cw-1:0]    r_i;
    logic [c_cw-1:0]    r_j;
    logic [c_cw-1:0]    r_k;
    logic               r_valid;
    logic               r_sat;

    logic [ACC_W:0]     w_add    [c_ne];
    logic [ACC_W:0]     w_sub    [c_ne];
    logic [ACC_W-1:0]   w_ew_val [c_ne];
    logic [c_ne-1:0]    w_ew_clamp;

    logic [c_iw-1:0]    w_ik_idx;
    logic [c_iw-1:0]    w_kj_idx;
    logic [c_iw-1:0]    w_ij_idx;
    logic [2*EW-1:0]    w_prod;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_mac_full;
    logic               w_mac_clamp;
    logic [ACC_W-1:0]   w_mac_val;

    // Element-wise ADD/SUB datapath; the extra MSB is carry (ADD) or borrow (SUB).
    always_comb begin
        w_ew_clamp = '0;
        for (int e = 0; e < c_ne; e++) begin
            w_add[e] = (ACC_W+1)'(r_a[e]) + (ACC_W+1)'(r_b[e]);
            w_sub[e] = (ACC_W+1)'(r_a[e]) - (ACC_W+1)'(r_b[e]);
            if (r_op == c_op_add) begin
                w_ew_clamp[e] = c_sat_en && w_add[e][ACC_W];
                w_ew_val[e]   = w_ew_clamp[e] ? '1 : w_add[e][ACC_W-1:0];
            end else begin
                w_ew_clamp[e] = c_sat_en && w_sub[e][ACC_W];
                w_ew_val[e]   = w_ew_clamp[e] ? '0 : w_sub[e][ACC_W-1:0];
            end
        end
    end

    assign w_ik_idx = c_iw'(r_i) * c_iw'(N) + c_iw'(r_k);
    assign w_kj_idx = c_iw'(r_k) * c_iw'(N) + c_iw'(r_j);
    assign w_ij_idx = c_iw'(r_i) * c_iw'(N) + c_iw'(r_j);
    assign w_prod   = (2*EW)'(r_a[w_ik_idx]) * (2*EW)'(r_b[w_kj_idx]);

    // At k == 0 the running sum restarts: from zero for MUL, from R[i][j] for MAC.
    assign w_base      = (r_k != '0) ? r_sum :
                         ((r_op == c_op_mul) ? '0 : r_acc[w_ij_idx]);
    assign w_mac_full  = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_prod);
    assign w_mac_clamp = c_sat_en && w_mac_full[ACC_W];
    assign w_mac_val   = w_mac_clamp ? '1 : w_mac_full[ACC_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_sum   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            for (int e = 0; e < c_ne; e++) begin
                r_a[e]   <= '0;
                r_b[e]   <= '0;
                r_acc[e] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_i) begin
                        r_sat <= 1'b0;
                        for (int e = 0; e < c_ne; e++) r_acc[e] <= '0;
                    end else if (bus.valid_i) begin
                        r_op  <= bus.opcode_i;
                        r_sat <= 1'b0;
                        r_i   <= '0;
                        r_j   <= '0;
                        r_k   <= '0;
                        for (int e = 0; e < c_ne; e++) begin
                            r_a[e] <= bus.mat_a_i[(c_ne-1-e)*EW +: EW];
                            r_b[e] <= bus.mat_b_i[(c_ne-1-e)*EW +: EW];
                        end
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!r_op[1]) begin
                        for (int e = 0; e < c_ne; e++) r_acc[e] <= w_ew_val[e];
                        if (|w_ew_clamp) r_sat <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (w_mac_clamp) r_sat <= 1'b1;
                        if (r_k == c_last) begin
                            r_acc[w_ij_idx] <= w_mac_val;
                            r_k <= '0;
                            if (r_j == c_last) begin
                                r_j <= '0;
                                if (r_i == c_last) begin
                                    r_i     <= '0;
                                    r_state <= S_DONE;
                                end else begin
                                    r_i <= r_i + 1'b1;
                                end
                            end else begin
                                r_j <= r_j + 1'b1;
                            end
                        end else begin
                            r_sum <= w_mac_val;
                            r_k   <= r_k + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // valid_o rises one cycle after entering DONE and holds until taken.
                    if (r_valid && bus.ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o = (r_state == S_IDLE) && !clr_i;
    assign bus.valid_o = r_valid;
    assign bus.sat_o   = r_sat;

    for (genvar e = 0; e < c_ne; e++) begin : g_out
        assign bus.result_o[(c_ne-1-e)*ACC_W +: ACC_W] = r_acc[e];
    end

endmodule

`default_nettype wire

// File: tb/tb_mat_mac_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_mat_mac_seq
// Brief   : Directed scoreboard bench for mat_mac_seq (N=3, EW=8, ACC_W=20).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mat_mac_seq;

    localparam int N     = 3;
    localparam int EW    = 8;
    localparam int ACC_W = 20;
    localparam int NE    = N * N;
    localparam int AW    = NE * EW;
    localparam int RW    = NE * ACC_W;

`ifdef MAT_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    mat_mac_seq_if #(.N(N), .EW(EW), .ACC_W(ACC_W)) bus ();

    mat_mac_seq #(.N(N), .EW(EW), .ACC_W(ACC_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]    tag;
        logic [RW-1:0] res;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [RW-1:0] fill_r(input logic [ACC_W-1:0] v);
        logic [RW-1:0] x;
        for (int e = 0; e < NE; e++) x[e*ACC_W +: ACC_W] = v;
        return x;
    endfunction

    function automatic logic [AW-1:0] fill_a(input logic [EW-1:0] v);
        logic [AW-1:0] x;
        for (int e = 0; e < NE; e++) x[e*EW +: EW] = v;
        return x;
    endfunction

    function automatic logic [AW-1:0] ident_a();
        logic [AW-1:0] x;
        for (int e = 0; e < NE; e++) x[(NE-1-e)*EW +: EW] = (e % (N + 1) == 0) ? EW'(1) : EW'(0);
        return x;
    endfunction

    function automatic logic [AW-1:0] seq_a();
        logic [AW-1:0] x;
        for (int e = 0; e < NE; e++) x[(NE-1-e)*EW +: EW] = EW'(e + 1);
        return x;
    endfunction

    function automatic logic [RW-1:0] seq_r();
        logic [RW-1:0] x;
        for (int e = 0; e < NE; e++) x[(NE-1-e)*ACC_W +: ACC_W] = ACC_W'(e + 1);
        return x;
    endfunction

    // Monitor: every accepted result is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", bus.result_o);
                end else begin
                    m_e = sb.pop_front();
                    chk($sformatf("result[%0d]", m_e.tag), bus.result_o, m_e.res);
                    chk($sformatf("sat[%0d]", m_e.tag), RW'(bus.sat_o), RW'(m_e.sat));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", RW'(n), RW'(0));
    endtask

    task automatic do_op(input logic [7:0] tag, input logic [1:0] op,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [RW-1:0] er, input logic es, input int lat);
        int n;
        bit rdy_bad;
        wait_idle();
        sb.push_back('{tag: tag, res: er, sat: es});
        bus.opcode_i = op;
        bus.mat_a_i  = a;
        bus.mat_b_i  = b;
        bus.valid_i  = 1'b1;
        @(posedge clk); #1;
        bus.valid_i  = 1'b0;
        bus.mat_a_i  = ~a;
        bus.mat_b_i  = ~b;
        n = 0;
        rdy_bad = 1'b0;
        while (bus.valid_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus.ready_o !== 1'b0) rdy_bad = 1'b1;
        end
        chk($sformatf("latency[%0d]", tag), RW'(n), RW'(lat));
        chk($sformatf("ready_low_busy[%0d]", tag), RW'(rdy_bad), RW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] snap;
        bit bad;
        bus.valid_i  = 1'b0;
        bus.opcode_i = '0;
        bus.mat_a_i  = '0;
        bus.mat_b_i  = '0;
        bus.ready_i  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", RW'(bus.ready_o), RW'(1));
        chk("rst_valid", RW'(bus.valid_o), RW'(0));
        chk("rst_result", bus.result_o, RW'(0));
        chk("rst_sat", RW'(bus.sat_o), RW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'd1, OP_ADD, fill_a(8'd5), fill_a(8'd3), fill_r(20'd8), 1'b0, 2);
        do_op(8'd2, OP_SUB, fill_a(8'd1), fill_a(8'd2),
              SAT ? fill_r(20'd0) : fill_r(20'hFFFFF), SAT, 2);
        do_op(8'd3, OP_MUL, ident_a(), seq_a(), seq_r(), 1'b0, 28);

        wait_idle();
        clr = 1'b1;
        #1;
        chk("clr_ready_low", RW'(bus.ready_o), RW'(0));
        @(posedge clk); #1;
        clr = 1'b0;
        do_op(8'd4, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd195075), 1'b0, 28);
        do_op(8'd5, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd390150), 1'b0, 28);
        do_op(8'd6, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd585225), 1'b0, 28);

        // Clear and valid together: the clear wins, the operation lands next cycle.
        wait_idle();
        clr          = 1'b1;
        bus.opcode_i = OP_MAC;
        bus.mat_a_i  = fill_a(8'd255);
        bus.mat_b_i  = fill_a(8'd255);
        bus.valid_i  = 1'b1;
        #1;
        chk("clr_valid_ready", RW'(bus.ready_o), RW'(0));
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        chk("clr_valid_not_taken", RW'(bus.ready_o), RW'(1));
        do_op(8'd7, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd195075), 1'b0, 28);
        do_op(8'd8, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd390150), 1'b0, 28);
        do_op(8'd9, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd585225), 1'b0, 28);
        do_op(8'd10, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd780300), 1'b0, 28);
        do_op(8'd11, OP_MAC, fill_a(8'd255), fill_a(8'd255), fill_r(20'd975375), 1'b0, 28);
        do_op(8'd12, OP_MAC, fill_a(8'd255), fill_a(8'd255),
              SAT ? fill_r(20'hFFFFF) : fill_r(20'd121874), SAT, 28);

        // Backpressure in DONE with stray valid_i pulses.
        wait_idle();
        bus.ready_i = 1'b0;
        do_op(8'd13, OP_ADD, fill_a(8'd5), fill_a(8'd3), fill_r(20'd8), 1'b0, 2);
        snap = bus.result_o;
        bad  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.valid_i = ~bus.valid_i;
            @(posedge clk); #1;
            if (bus.valid_o !== 1'b1 || bus.result_o !== snap || bus.ready_o !== 1'b0) bad = 1'b1;
        end
        bus.valid_i = 1'b0;
        chk("bp_stable", RW'(bad), RW'(0));
        chk("bp_value", snap, fill_r(20'd8));
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_back", RW'(bus.ready_o), RW'(1));
        chk("bp_valid_drop", RW'(bus.valid_o), RW'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_stray_op", RW'({bus.ready_o, bus.valid_o}), RW'(2'b10));

        // Asynchronous reset in the middle of a MUL.
        wait_idle();
        bus.opcode_i = OP_MUL;
        bus.mat_a_i  = ident_a();
        bus.mat_b_i  = seq_a();
        bus.valid_i  = 1'b1;
        @(posedge clk); #1;
        bus.valid_i  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", RW'(bus.valid_o), RW'(0));
        chk("mid_rst_result", bus.result_o, RW'(0));
        chk("mid_rst_ready", RW'(bus.ready_o), RW'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(8'd14, OP_ADD, fill_a(8'd5), fill_a(8'd3), fill_r(20'd8), 1'b0, 2);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", RW'(sb.size()), RW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
